// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcodes and
// programcounter mode codes.
package riscv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT
    } seq_state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_PLUS4   = 2'b00;
    localparam logic [1:0] PC_IMM     = 2'b01;
    localparam logic [1:0] PC_RS1_IMM = 2'b10;
    localparam logic [1:0] PC_IMM_HI  = 2'b11;

    localparam logic [24:0] EBREAK_HI = 25'h0002000;

    function automatic logic is_ebreak(input logic [31:0] ins);
        return (ins[6:0] == OP_SYSTEM) && (ins[31:7] == EBREAK_HI);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational J/I/B immediate extraction, sign-extended to OFFSET_W bits.
module imm_decode
    import riscv_pkg::*;
#(
    parameter int OFFSET_W = 22
) (
    input  logic        [31:7]         instr_hi,
    output logic signed [OFFSET_W-1:0] j_imm,
    output logic signed [OFFSET_W-1:0] i_imm,
    output logic signed [OFFSET_W-1:0] b_imm
);

    localparam int JW = 21;
    localparam int IW = 12;
    localparam int BW = 13;

    logic [JW-1:0] j_raw;
    logic [IW-1:0] i_raw;
    logic [BW-1:0] b_raw;

    // Bit 0 of the J and B offsets is implicitly zero in the encoding.
    assign j_raw = {instr_hi[31], instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};
    assign i_raw = instr_hi[31:20];
    assign b_raw = {instr_hi[31], instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};

    assign j_imm = {{(OFFSET_W-JW){j_raw[JW-1]}}, j_raw};
    assign i_imm = {{(OFFSET_W-IW){i_raw[IW-1]}}, i_raw};
    assign b_imm = {{(OFFSET_W-BW){b_raw[BW-1]}}, b_raw};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute/update sequencer driving the programcounter datapath.
// Optional fetch watchdog enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int OFFSET_W = 22,
    parameter int TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    input  logic                imem_ack,
    input  logic [31:0]         imem_data,
    input  logic                exec_done,
    input  logic                branch_taken,
    output logic                imem_req,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [1:0]          pc_func,
    output logic [OFFSET_W-1:0] pc_offset,
    output logic [4:0]          pc_rs1,
    output logic                pc_en,
    output logic                halted,
    output logic                fetch_err
);

    seq_state_t state;
    logic       halt_pend;
    logic       fetch_to;

    logic signed [OFFSET_W-1:0] j_imm;
    logic signed [OFFSET_W-1:0] i_imm;
    logic signed [OFFSET_W-1:0] b_imm;

    imm_decode #(.OFFSET_W(OFFSET_W)) u_imm (
        .instr_hi (instr[31:7]),
        .j_imm    (j_imm),
        .i_imm    (i_imm),
        .b_imm    (b_imm)
    );

`ifdef PC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wd_cnt;

    // Counter sits at zero outside FETCH, so every FETCH entry starts fresh.
    assign fetch_to = (state == ST_FETCH) && !imem_ack && (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == ST_FETCH && !imem_ack && !fetch_to)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (fetch_to)
                fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_to  = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            halt_pend   <= 1'b0;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_func     <= PC_PLUS4;
            pc_offset   <= '0;
            pc_rs1      <= '0;
            pc_en       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc_en <= 1'b0;
            if (state != ST_IDLE && state != ST_HALT && halt_req)
                halt_pend <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_data;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_DECODE;
                    end else if (fetch_to) begin
                        imem_req  <= 1'b0;
                        halted    <= 1'b1;
                        halt_pend <= 1'b0;
                        state     <= ST_HALT;
                    end
                end
                ST_DECODE: begin
                    // Branches assume taken here; EXEC corrects it once the outcome is known.
                    pc_func   <= PC_PLUS4;
                    pc_offset <= '0;
                    pc_rs1    <= '0;
                    unique case (instr[6:0])
                        OP_JAL: begin
                            pc_func   <= PC_IMM;
                            pc_offset <= j_imm;
                        end
                        OP_JALR: begin
                            pc_func   <= PC_RS1_IMM;
                            pc_offset <= i_imm;
                            pc_rs1    <= instr[19:15];
                        end
                        OP_BRANCH: begin
                            pc_func   <= PC_IMM;
                            pc_offset <= b_imm;
                        end
                        default: ;
                    endcase
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        if (instr[6:0] == OP_BRANCH && !branch_taken) begin
                            pc_func   <= PC_PLUS4;
                            pc_offset <= '0;
                        end
                        pc_en <= 1'b1;
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    instr_valid <= 1'b0;
                    if (halt_pend || halt_req || is_ebreak(instr)) begin
                        halted    <= 1'b1;
                        halt_pend <= 1'b0;
                        state     <= ST_HALT;
                    end else begin
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        halted <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; watchdog case runs when
// PC_SEQ_TIMEOUT_EN is defined.
module tb_pc_sequencer;

`ifdef PC_SEQ_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 16;
`endif
    localparam int OW = 22;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_data = '0;
    logic          exec_done = 1'b0;
    logic          branch_taken = 1'b0;
    logic          imem_req;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [1:0]    pc_func;
    logic [OW-1:0] pc_offset;
    logic [4:0]    pc_rs1;
    logic          pc_en;
    logic          halted;
    logic          fetch_err;

    int total = 0;
    int bad = 0;
    int en_cnt = 0;

    pc_sequencer #(.OFFSET_W(OW), .TIMEOUT(TB_TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .halt_req     (halt_req),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc_func      (pc_func),
        .pc_offset    (pc_offset),
        .pc_rs1       (pc_rs1),
        .pc_en        (pc_en),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (pc_en === 1'b1) en_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic [31:0]   ins;
        logic          taken;
        int            ack_wait;
        logic          early;
        logic [1:0]    func;
        logic [OW-1:0] off;
        logic [4:0]    rs1;
        logic          halt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   imem_req, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_en"},    pc_en, 0);
        chk({tag, "_halt"},  halted, 0);
        chk({tag, "_ferr"},  fetch_err, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_func"},  pc_func, 0);
        chk({tag, "_off"},   pc_offset, 0);
        chk({tag, "_rs1"},   pc_rs1, 0);
    endtask

    // Runs one instruction from FETCH to just past UPDATE; returns what UPDATE showed.
    task automatic run_instr(input logic [31:0] ins, input logic taken, input int ack_wait,
                             input logic early, output logic [1:0] f, output logic [OW-1:0] o,
                             output logic [4:0] r, output logic [31:0] li);
        int guard;
        guard = 0;
        while (imem_req !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("req_seen", imem_req, 1);
        for (int k = 0; k < ack_wait; k++) begin
            @(negedge clock);
            chk("req_held", imem_req, 1);
        end
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = 32'hDEADBEEF;
        chk("req_drop", imem_req, 0);
        chk("valid_dec", instr_valid, 1);
        exec_done    = early;
        branch_taken = ~taken;
        @(negedge clock);
        chk("en_exec", pc_en, 0);
        exec_done    = 1'b1;
        branch_taken = taken;
        @(negedge clock);
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        chk("en_upd", pc_en, 1);
        chk("valid_upd", instr_valid, 1);
        f  = pc_func;
        o  = pc_offset;
        r  = pc_rs1;
        li = instr;
        @(negedge clock);
        chk("en_once", pc_en, 0);
    endtask

    logic [1:0]    f;
    logic [OW-1:0] o;
    logic [4:0]    r;
    logic [31:0]   li;
    int            base;

    initial begin
        vecs[0] = '{32'h00000013, 1'b0, 0, 1'b0, 2'b00, 22'h000000, 5'd0, 1'b0};
        vecs[1] = '{32'h008000EF, 1'b0, 2, 1'b0, 2'b01, 22'h000008, 5'd0, 1'b0};
        vecs[2] = '{32'hFFC08067, 1'b0, 0, 1'b1, 2'b10, 22'h3FFFFC, 5'd1, 1'b0};
        vecs[3] = '{32'hFE000EE3, 1'b1, 0, 1'b0, 2'b01, 22'h3FFFFC, 5'd0, 1'b0};
        vecs[4] = '{32'hFE000EE3, 1'b0, 1, 1'b0, 2'b00, 22'h000000, 5'd0, 1'b0};
        vecs[5] = '{32'h00500093, 1'b0, 0, 1'b0, 2'b00, 22'h000000, 5'd0, 1'b0};
        vecs[6] = '{32'h00000073, 1'b0, 0, 1'b0, 2'b00, 22'h000000, 5'd0, 1'b0};
        vecs[7] = '{32'h00100073, 1'b0, 0, 1'b0, 2'b00, 22'h000000, 5'd0, 1'b1};

        #2 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b1;

        halt_req = 1'b1;
        repeat (2) @(negedge clock);
        halt_req = 1'b0;
        chk("idle_req", imem_req, 0);

        do_start();
        chk("start_req", imem_req, 1);
        for (int i = 0; i < 8; i++) begin
            run_instr(vecs[i].ins, vecs[i].taken, vecs[i].ack_wait, vecs[i].early, f, o, r, li);
            chk($sformatf("v%0d_func", i), f, vecs[i].func);
            chk($sformatf("v%0d_off", i), o, vecs[i].off);
            chk($sformatf("v%0d_rs1", i), r, vecs[i].rs1);
            chk($sformatf("v%0d_instr", i), li, vecs[i].ins);
            chk($sformatf("v%0d_halt", i), halted, vecs[i].halt);
            chk($sformatf("v%0d_req", i), imem_req, !vecs[i].halt);
        end

        do_start();
        chk("halt_exit", halted, 0);
        chk("idle_after_halt", imem_req, 0);
        @(negedge clock);
        chk("idle_stays", imem_req, 0);

        do_start();
        halt_req = 1'b1;
        start    = 1'b1;
        @(negedge clock);
        halt_req = 1'b0;
        start    = 1'b0;
        run_instr(32'h00000013, 1'b0, 0, 1'b0, f, o, r, li);
        chk("hreq_halt", halted, 1);
        chk("hreq_req", imem_req, 0);
        do_start();
        chk("hreq_exit", halted, 0);

        do_start();
        halt_req = 1'b1;
        @(negedge clock);
        halt_req = 1'b0;
        run_instr(32'h00100073, 1'b0, 0, 1'b0, f, o, r, li);
        chk("both_halt", halted, 1);
        do_start();
        chk("both_exit", halted, 0);
        @(negedge clock);
        chk("both_idle_req", imem_req, 0);
        chk("both_idle_halt", halted, 0);

        do_start();
        imem_ack  = 1'b1;
        imem_data = 32'h008000EF;
        @(negedge clock);
        imem_ack = 1'b0;
        @(negedge clock);
        base      = en_cnt;
        exec_done = 1'b1;
        reset     = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(negedge clock);
        chk("mid_en_hold", pc_en, 0);
        exec_done = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        chk("mid_idle_req", imem_req, 0);
        repeat (2) @(negedge clock);
        chk("mid_no_pulse", en_cnt, base);
        do_start();
        chk("mid_restart", imem_req, 1);
        run_instr(32'h00000013, 1'b0, 0, 1'b0, f, o, r, li);
        chk("mid_nop_func", f, 0);
        chk("mid_pulses", en_cnt, base + 1);

`ifdef PC_SEQ_TIMEOUT_EN
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_start();
        repeat (3) @(negedge clock);
        chk("to_pre_err", fetch_err, 0);
        chk("to_pre_req", imem_req, 1);
        @(negedge clock);
        chk("to_err", fetch_err, 1);
        chk("to_halt", halted, 1);
        chk("to_req", imem_req, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer for the RISC-V core: runs the fetch/decode/execute/update loop and drives the `programcounter` datapath's `func`, `offset` and `rs1` inputs plus a one-cycle PC update strobe. Sits between instruction memory, the execute stage (ALU/branch compare) and the `programcounter`. It decides each next-PC mode (sequential, PC-relative jump/branch, register-indirect) from the fetched instruction and the branch outcome.

## Interface
- `OFFSET_W`, 22: width of `pc_offset`.
- `TIMEOUT`, 16: fetch watchdog limit in cycles; used only with `PC_SEQ_TIMEOUT_EN`.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: leave IDLE and begin fetching.
- `halt_req` in 1: stop after the current instruction retires.
- `imem_ack` in 1: instruction memory has valid data on `imem_data`.
- `imem_data` in 32: fetched instruction.
- `exec_done` in 1: execute stage finished; `branch_taken` is valid in the same cycle.
- `branch_taken` in 1: branch condition result.
- `imem_req` out 1: fetch request, held until acknowledged.
- `instr` out 32: latched current instruction.
- `instr_valid` out 1: `instr` is valid, from DECODE through UPDATE.
- `pc_func` out 2: `programcounter` mode. 00 = +4, 01 = +imm, 10 = rs1+imm, 11 = +(imm<<12).
- `pc_offset` out OFFSET_W: sign-extended immediate.
- `pc_rs1` out 5: register index for mode 10.
- `pc_en` out 1: PC update strobe, exactly one cycle per instruction.
- `halted` out 1: sequencer is in HALT.
- `fetch_err` out 1: watchdog fired; sticky until reset.

## Operation
- States and transitions:
  - IDLE → FETCH on `start`.
  - FETCH → DECODE on `imem_ack`.
  - DECODE → EXEC (always, one cycle).
  - EXEC → UPDATE on `exec_done`.
  - UPDATE → FETCH, or UPDATE → HALT if `halt_req` is pending or the instruction was EBREAK.
  - HALT → IDLE on `start`.
- `imem_data` is latched into `instr` on the FETCH cycle in which `imem_ack` is high.
- Decode rules (opcode = `instr[6:0]`):
  - 1101111 JAL: func 01, offset = J-imm.
  - 1100111 JALR: func 10, rs1 = `instr[19:15]`, offset = I-imm.
  - 1100011 BRANCH: func 01 with B-imm if `branch_taken` (sampled at `exec_done`), else func 00 with offset 0.
  - 1110011 with `instr[31:7]` == 0x2000 (EBREAK): func 00, then HALT.
  - All others: func 00, offset 0.
- All immediates are sign-extended to OFFSET_W bits; the J-imm bit 0 is included as 0.
- Func 11 is never issued by this block; the encoding is reserved.
- `pc_func`, `pc_offset` and `pc_rs1` are registered in DECODE. The branch decision is re-registered on the `exec_done` edge. All three hold stable through UPDATE.
- `halt_req` is sticky-captured in any state other than IDLE/HALT, and cleared on entry to HALT.
- `halt_req` in IDLE is ignored.
- `start` outside IDLE/HALT is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `imem_req`, `instr_valid`, `pc_en`, `halted`, `fetch_err` = 0.
  - `instr` = 0, `pc_func` = 00, `pc_offset` = 0, `pc_rs1` = 0.
- `imem_req` is high throughout FETCH and drops the cycle after `imem_ack` is seen.
- Minimum instruction time is 4 cycles (FETCH, DECODE, EXEC, UPDATE), with `imem_ack` and `exec_done` each arriving in the first cycle they are looked for.
- `pc_en` is high only in UPDATE.
- `exec_done` asserted during DECODE is ignored.
- Reset asserted mid-instruction: return to IDLE immediately. No `pc_en` pulse is emitted, and the watchdog counter clears.
- `halt_req` and EBREAK in the same instruction: a single HALT entry.

## Configuration
- `PC_SEQ_TIMEOUT_EN` defined:
  - A counter runs during FETCH.
  - If `imem_ack` has not arrived after TIMEOUT cycles in FETCH, `fetch_err` is set, `imem_req` drops and the state moves to HALT.
  - The counter clears on each FETCH entry.
- Macro undefined:
  - No counter is built.
  - FETCH waits indefinitely.
  - `fetch_err` is tied to 0.

## Structure
- Shared package `riscv_pkg` holds:
  - State enum.
  - Opcode constants (OP_JAL, OP_JALR, OP_BRANCH, OP_SYSTEM).
  - PC func codes (PC_PLUS4, PC_IMM, PC_RS1_IMM, PC_IMM_HI).
- One sub-module, `imm_decode`: combinational extraction and sign-extension of the J/I/B immediates to OFFSET_W bits.

## Test plan
- Reset low mid-EXEC → all outputs return to reset values; no `pc_en` pulse is seen; `start` then restarts from FETCH.
- `start`, then NOP (0x00000013) with ack and `exec_done` each 1 cycle → `pc_en` once 4 cycles after FETCH entry, `pc_func` = 00.
- JAL 0x008000EF → `pc_func` = 01, `pc_offset` = 8.
- JALR 0xFFC08067 → `pc_func` = 10, `pc_rs1` = 1, `pc_offset` = 0x3FFFFC (−4).
- BEQ 0xFE000EE3 (B-imm = −4):
  - with `branch_taken` = 1 → func 01, offset 0x3FFFFC;
  - with `branch_taken` = 0 → func 00, offset 0.
- EBREAK 0x00100073 → `halted` = 1 after UPDATE; a later `start` → IDLE.
- With `PC_SEQ_TIMEOUT_EN` defined, TIMEOUT = 4 and no ack → `fetch_err` = 1 and `halted` = 1 after 4 FETCH cycles.
